dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the CPU core (port 0) and a debug/loader master (port 1).
//  Fixed priority to the CPU, with a starvation override for debug and a CPU lock for read-modify-write.
//  Sits between the controller/ALU address path and data memory; memory has synchronous read, 1-cycle latency.
// PARAMETERS
//  AW            8    data-memory address width (words)
//  DW            16   data width
//  STARVE_LIMIT  4    debug wait cycles before debug gets priority (>=1)
// PORTS
//  clk         in   1   system clock; single clock domain
//  rst         in   1   synchronous reset, active-high
//  cpu_req     in   1   CPU access request; req/we/addr/wdata held stable until cpu_gnt
//  cpu_we      in   1   1=write, 0=read
//  cpu_lock    in   1   keep port owned by CPU after this grant
//  cpu_addr    in   AW  word address
//  cpu_wdata   in   DW  write data
//  cpu_gnt     out  1   request accepted this cycle (combinational)
//  cpu_rvalid  out  1   read data valid (registered)
//  cpu_rdata   out  DW  read data
//  dbg_req     in   1   debug request; same hold rule
//  dbg_we      in   1   1=write, 0=read
//  dbg_addr    in   AW  word address
//  dbg_wdata   in   DW  write data
//  dbg_gnt     out  1   request accepted this cycle (combinational)
//  dbg_rvalid  out  1   read data valid (registered)
//  dbg_rdata   out  DW  read data
//  mem_en      out  1   memory access strobe
//  mem_we      out  1   memory write enable
//  mem_addr    out  AW  memory address
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory read data, valid the cycle after mem_en & ~mem_we
// BEHAVIOUR
//  Reset: state=ARB; wait_cnt=0; rvalid=0 and rdata=0 on both ports; rsp_owner=CPU.
//   While rst=1: all gnt=0, mem_en=0, mem_we=0.
//  Grant: at most one gnt per cycle. mem_en=cpu_gnt|dbg_gnt. mem_we/addr/wdata are muxed from the winner.
//   When idle: mem_en=0 and mem_we=0; addr/wdata are don't-care (drive 0).
//  FSM ARB:
//   - dbg wins if dbg_req & (wait_cnt==STARVE_LIMIT | ~cpu_req); otherwise cpu wins if cpu_req.
//   - cpu_gnt & cpu_lock -> LOCK.
//  FSM LOCK:
//   - Only the CPU is granted; dbg_gnt=0 regardless of wait_cnt.
//   - cpu_lock=0 -> ARB next cycle; a CPU access issued in that same cycle is still granted.
//   - Debug becomes eligible the cycle after lock drops.
//  wait_cnt:
//   - Increments when dbg_req & ~dbg_gnt; saturates at STARVE_LIMIT.
//   - Clears on dbg_gnt, and when dbg_req=0.
//  Read response:
//   - Read granted in cycle N -> owner rvalid=1 in N+1 with rdata=mem_rdata; owner tag registered at grant.
//   - rvalid is a 1-cycle pulse. Non-owner rdata holds its last value.
//   - Back-to-back reads give one response per cycle, in grant order.
//  Writes: complete at the grant edge; no rvalid.
//   - A read of the same address granted the next cycle returns the new data.
//  Reset mid-operation: a read granted in the cycle before rst produces no rvalid; LOCK is abandoned.
//  Protocol violation (req dropped before gnt): no error; the request is simply lost.
// STRUCTURE
//  Shared package risc16_pkg: DMEM_AW, DATA_W, PORT_CPU/PORT_DBG ids, arb state encoding (ARB, LOCK).
//  Flat module: 2-state FSM, saturating wait counter, response-tag register.
//  No sub-module is natural.
// TESTING
//  1. mem[201]=12; cpu read 201 at cycle 0 -> cpu_gnt=1 @0; cpu_rvalid=1, cpu_rdata=12 @1.
//  2. Both read @0 (cpu 202=4, dbg 201=12), held -> cpu_gnt @0, dbg_gnt @1;
//     cpu_rdata=4 @1; dbg_rdata=12 @2.
//  3. STARVE_LIMIT=4; cpu_req held high continuously, dbg_req high from 0 -> dbg_gnt=0 @0-3;
//     dbg_gnt=1, cpu_gnt=0 @4; cpu resumes @5.
//  4. cpu_lock=1: read 204 @0, write 204 @1 with lock dropped; dbg_req high from 0 -> dbg_gnt=0 @0-1; dbg_gnt=1 @2.
//  5. cpu read granted @0, rst=1 @1 -> cpu_rvalid=0 @1 and @2; all outputs at reset values.
//  6. dbg write 205=16'h55AA @0, cpu read 205 @1 -> cpu_rvalid=1, cpu_rdata=16'h55AA @2.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared RISC16 definitions: data-memory geometry, port ids and the
// data-memory arbiter state encoding.
package risc16_pkg;

    localparam int DMEM_AW = 8;
    localparam int DATA_W  = 16;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single synchronous-read data-memory port between the CPU (fixed
// priority, with a read-modify-write lock) and the debug/loader master.
module dmem_port_arbiter
    import risc16_pkg::*;
#(
    parameter int AW           = DMEM_AW,
    parameter int DW           = DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_lock,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          rsp_valid_q;
    port_e         rsp_owner_q;
    logic [DW-1:0] cpu_hold_q, dbg_hold_q;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB: begin
                    if (dbg_req && (wait_q == LIMIT || !cpu_req)) begin
                        dbg_gnt = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                        if (cpu_lock) state_d = LOCK;
                    end
                end
                LOCK: begin
                    cpu_gnt = cpu_req;
                    if (!cpu_lock) state_d = ARB;
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!dbg_req || dbg_gnt) begin
            wait_d = '0;
        end else if (wait_q != LIMIT) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= PORT_CPU;
            cpu_hold_q  <= '0;
            dbg_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rsp_valid_q <= mem_en & ~mem_we;
            if (mem_en) rsp_owner_q <= dbg_gnt ? PORT_DBG : PORT_CPU;
            if (cpu_rvalid) cpu_hold_q <= mem_rdata;
            if (dbg_rvalid) dbg_hold_q <= mem_rdata;
        end
    end

    // Memory data arrives the cycle after the grant, so the response is steered
    // from mem_rdata directly and remembered for the hold-last-value behaviour.
    // Reset masks a response still in flight from the previous cycle.
    assign cpu_rvalid = rsp_valid_q & ~rst & (rsp_owner_q == PORT_CPU);
    assign dbg_rvalid = rsp_valid_q & ~rst & (rsp_owner_q == PORT_DBG);
    assign cpu_rdata  = rst ? '0 : (cpu_rvalid ? mem_rdata : cpu_hold_q);
    assign dbg_rdata  = rst ? '0 : (dbg_rvalid ? mem_rdata : dbg_hold_q);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: grant expectations are checked per
// cycle; read responses go through a scoreboard queue of expected data.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [15:0] dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [15:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    dmem_port_arbiter #(.AW(8), .DW(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int a);
        case (a)
            201:     return 16'd12;
            202:     return 16'd4;
            default: return {8'hA5, 8'(a)};
        endcase
    endfunction

    // Synchronous-read memory model, loaded while reset is held.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        bit          port;
        logic [15:0] data;
        int          due;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [15:0] ref_mem [256];
    int          cyc_cnt = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cpu_hold = '0;
    logic [15:0] exp_dbg_hold = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc_cnt, got, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Response monitor: compares both read ports against the scoreboard each cycle.
    always @(negedge clk) begin
        logic cpu_due, dbg_due;
        logic [15:0] due_data;
        cpu_due  = 1'b0;
        dbg_due  = 1'b0;
        due_data = '0;
        if (rst) begin
            exp_cpu_hold = '0;
            exp_dbg_hold = '0;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
            due_data = exp_q[0].data;
            if (exp_q[0].port) begin
                dbg_due      = 1'b1;
                exp_dbg_hold = due_data;
            end else begin
                cpu_due      = 1'b1;
                exp_cpu_hold = due_data;
            end
            void'(exp_q.pop_front());
        end
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(cpu_due));
        check("dbg_rvalid", 32'(dbg_rvalid), 32'(dbg_due));
        check("cpu_rdata",  32'(cpu_rdata),  32'(exp_cpu_hold));
        check("dbg_rdata",  32'(dbg_rdata),  32'(exp_dbg_hold));
    end

    // Called just after a rising edge: applies one cycle of stimulus, checks the
    // combinational grant path at the falling edge and books expected responses.
    task automatic drive_cycle(
        input logic r,
        input logic c_req, input logic c_we, input logic c_lock,
        input logic [7:0] c_addr, input logic [15:0] c_wd,
        input logic d_req, input logic d_we,
        input logic [7:0] d_addr, input logic [15:0] d_wd,
        input logic e_cg, input logic e_dg);
        rst = r;
        cpu_req = c_req; cpu_we = c_we; cpu_lock = c_lock; cpu_addr = c_addr; cpu_wdata = c_wd;
        dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
        if (r) begin
            while (exp_q.size() > 0 && exp_q[0].due <= cyc_cnt) void'(exp_q.pop_front());
        end
        @(negedge clk);
        check("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
        check("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
        check("mem_en",  32'(mem_en),  32'(e_cg | e_dg));
        if (e_cg) begin
            check("mem_we_cpu",   32'(mem_we),   32'(c_we));
            check("mem_addr_cpu", 32'(mem_addr), 32'(c_addr));
            if (c_we) begin
                check("mem_wdata_cpu", 32'(mem_wdata), 32'(c_wd));
                ref_mem[c_addr] = c_wd;
            end else begin
                exp_q.push_back('{1'b0, ref_mem[c_addr], cyc_cnt + 1});
            end
        end else if (e_dg) begin
            check("mem_we_dbg",   32'(mem_we),   32'(d_we));
            check("mem_addr_dbg", 32'(mem_addr), 32'(d_addr));
            if (d_we) begin
                check("mem_wdata_dbg", 32'(mem_wdata), 32'(d_wd));
                ref_mem[d_addr] = d_wd;
            end else begin
                exp_q.push_back('{1'b1, ref_mem[d_addr], cyc_cnt + 1});
            end
        end else begin
            check("mem_we_idle", 32'(mem_we), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive_cycle(0, 0,0,0, 8'd0, 16'd0, 0,0, 8'd0, 16'd0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        @(posedge clk);
        #1;

        // Reset: requests present but nothing may be granted.
        drive_cycle(1, 1,0,0, 8'd201, 16'd0, 1,0, 8'd202, 16'd0, 0, 0);
        drive_cycle(1, 1,1,1, 8'd10,  16'd7, 1,1, 8'd11,  16'd9, 0, 0);
        idle();

        // Single CPU read: grant now, data next cycle.
        drive_cycle(0, 1,0,0, 8'd201, 16'd0, 0,0, 8'd0, 16'd0, 1, 0);
        idle();
        idle();

        // Both read: CPU first, debug next cycle.
        drive_cycle(0, 1,0,0, 8'd202, 16'd0, 1,0, 8'd201, 16'd0, 1, 0);
        drive_cycle(0, 0,0,0, 8'd0,   16'd0, 1,0, 8'd201, 16'd0, 0, 1);
        idle();
        idle();

        // Starvation: CPU streams reads, debug wins on the fifth waiting cycle.
        for (int i = 0; i < 4; i++)
            drive_cycle(0, 1,0,0, 8'(10 + i), 16'd0, 1,0, 8'd202, 16'd0, 1, 0);
        drive_cycle(0, 1,0,0, 8'd14, 16'd0, 1,0, 8'd202, 16'd0, 0, 1);
        drive_cycle(0, 1,0,0, 8'd14, 16'd0, 0,0, 8'd0,   16'd0, 1, 0);
        idle();
        idle();

        // Lock for read-modify-write: debug blocked until the cycle after lock drops.
        drive_cycle(0, 1,0,1, 8'd204, 16'd0,     1,0, 8'd204, 16'd0, 1, 0);
        drive_cycle(0, 1,1,0, 8'd204, 16'h1234,  1,0, 8'd204, 16'd0, 1, 0);
        drive_cycle(0, 0,0,0, 8'd0,   16'd0,     1,0, 8'd204, 16'd0, 0, 1);
        idle();
        idle();

        // Long lock: debug stays blocked even after its wait count saturates.
        drive_cycle(0, 1,0,1, 8'd30, 16'd0, 1,0, 8'd31, 16'd0, 1, 0);
        for (int i = 0; i < 5; i++)
            drive_cycle(0, 0,0,1, 8'd0, 16'd0, 1,0, 8'd31, 16'd0, 0, 0);
        drive_cycle(0, 1,0,0, 8'd32, 16'd0, 1,0, 8'd31, 16'd0, 1, 0);
        drive_cycle(0, 1,0,0, 8'd33, 16'd0, 1,0, 8'd31, 16'd0, 0, 1);
        idle();
        idle();

        // Reset mid-operation: in-flight read dropped, lock abandoned.
        drive_cycle(0, 1,0,1, 8'd201, 16'd0, 0,0, 8'd0, 16'd0, 1, 0);
        drive_cycle(1, 1,0,1, 8'd201, 16'd0, 1,0, 8'd201, 16'd0, 0, 0);
        drive_cycle(0, 0,0,0, 8'd0,   16'd0, 1,0, 8'd201, 16'd0, 0, 1);
        idle();
        idle();

        // Debug write followed by CPU read of the same word returns new data.
        drive_cycle(0, 0,0,0, 8'd0,   16'd0, 1,1, 8'd205, 16'h55AA, 0, 1);
        drive_cycle(0, 1,0,0, 8'd205, 16'd0, 0,0, 8'd0,   16'd0,    1, 0);
        idle();
        idle();

        check("rsp_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
